// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for a single device bus.
// Each transaction runs IDLE -> ADDR -> WAIT -> RESP and can end in an ack or a timeout abort.
module io_bus_arbiter #(
  parameter int unsigned DBITS     = 32,
  parameter int unsigned TIMEOUT   = 8,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             m0_req,
  input  logic             m0_wr,
  input  logic [DBITS-1:0] m0_addr,
  input  logic [DBITS-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_done,

  input  logic             m1_req,
  input  logic             m1_wr,
  input  logic [DBITS-1:0] m1_addr,
  input  logic [DBITS-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_done,

  output logic             err,
  output logic [DBITS-1:0] rdata,

  output logic [DBITS-1:0] bus_addr,
  output logic [DBITS-1:0] bus_wdata,
  output logic             bus_oe,
  output logic             bus_wrtEn,
  input  logic [DBITS-1:0] bus_rdata,
  input  logic             bus_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic             wr_q, wr_d;
  logic [DBITS-1:0] addr_q, addr_d;
  logic [DBITS-1:0] wdata_q, wdata_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cnt_inc;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             m0_gnt_q, m0_gnt_d;
  logic             m1_gnt_q, m1_gnt_d;
  logic             m0_done_q, m0_done_d;
  logic             m1_done_q, m1_done_d;
  logic             pick_m1;

  // ptr_q = 1 means m1 is favoured on a tie; it is ignored with fixed priority.
  assign pick_m1 = m1_req & (~m0_req | (~FIXED_PRI & ptr_q));
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    m0_gnt_d  = 1'b0;
    m1_gnt_d  = 1'b0;
    m0_done_d = 1'b0;
    m1_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d  = pick_m1;
          wr_d     = pick_m1 ? m1_wr    : m0_wr;
          addr_d   = pick_m1 ? m1_addr  : m0_addr;
          wdata_d  = pick_m1 ? m1_wdata : m0_wdata;
          cnt_d    = 4'd0;
          m0_gnt_d = ~pick_m1;
          m1_gnt_d = pick_m1;
          ptr_d    = ~pick_m1;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus_ack) begin
          rdata_d   = wr_q ? '0 : bus_rdata;
          err_d     = 1'b0;
          m0_done_d = ~owner_q;
          m1_done_d = owner_q;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutCnt) begin
            rdata_d   = '0;
            err_d     = 1'b1;
            m0_done_d = ~owner_q;
            m1_done_d = owner_q;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= 4'd0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      m0_gnt_q  <= 1'b0;
      m1_gnt_q  <= 1'b0;
      m0_done_q <= 1'b0;
      m1_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      m0_gnt_q  <= m0_gnt_d;
      m1_gnt_q  <= m1_gnt_d;
      m0_done_q <= m0_done_d;
      m1_done_q <= m1_done_d;
    end
  end

  // Bus strobes decode from the state register so a reset drops them without a clock.
  always_comb begin
    bus_addr  = '0;
    bus_oe    = 1'b0;
    bus_wrtEn = 1'b0;
    bus_wdata = '0;
    if (state_q == ADDR || state_q == WAIT) begin
      bus_addr = addr_q;
    end
    if (state_q == ADDR && wr_q) begin
      bus_oe    = 1'b1;
      bus_wrtEn = 1'b1;
      bus_wdata = wdata_q;
    end
  end

  assign m0_gnt  = m0_gnt_q;
  assign m1_gnt  = m1_gnt_q;
  assign m0_done = m0_done_q;
  assign m1_done = m1_done_q;
  assign rdata   = rdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with a completion scoreboard.
// A second instance with FIXED_PRI = 1 shares the stimulus to check fixed priority.
module tb_io_bus_arbiter;

  localparam int unsigned DBITS = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             m0_req, m0_wr, m1_req, m1_wr;
  logic [DBITS-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [DBITS-1:0] bus_rdata;
  logic             bus_ack;

  logic             m0_gnt, m1_gnt, m0_done, m1_done, err;
  logic [DBITS-1:0] rdata, bus_addr, bus_wdata;
  logic             bus_oe, bus_wrtEn;

  logic             fp_m0_gnt, fp_m1_gnt, fp_m0_done, fp_m1_done, fp_err;
  logic [DBITS-1:0] fp_rdata, fp_bus_addr, fp_bus_wdata;
  logic             fp_bus_oe, fp_bus_wrtEn;

  typedef struct packed {
    logic             who;
    logic [DBITS-1:0] rdata;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.DBITS(DBITS), .TIMEOUT(8), .FIXED_PRI(1'b0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done),
    .err(err), .rdata(rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_oe(bus_oe), .bus_wrtEn(bus_wrtEn),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  io_bus_arbiter #(.DBITS(DBITS), .TIMEOUT(8), .FIXED_PRI(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(fp_m0_gnt), .m0_done(fp_m0_done),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(fp_m1_gnt), .m1_done(fp_m1_done),
    .err(fp_err), .rdata(fp_rdata),
    .bus_addr(fp_bus_addr), .bus_wdata(fp_bus_wdata), .bus_oe(fp_bus_oe),
    .bus_wrtEn(fp_bus_wrtEn),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_out();
    return 128'({m0_gnt, m1_gnt, m0_done, m1_done, err, rdata, bus_addr, bus_wdata,
                 bus_oe, bus_wrtEn});
  endfunction

  task automatic push_exp(input logic who, input logic [DBITS-1:0] rd, input logic e);
    exp_t x;
    x.who   = who;
    x.rdata = rd;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  // Returns the granted master (or -1) and the number of falling edges waited.
  task automatic wait_gnt(input int max, output int who, output int cycles);
    bit got = 1'b0;
    who    = -1;
    cycles = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) begin
        who    = m1_gnt ? 1 : 0;
        cycles = i;
        got    = 1'b1;
        break;
      end
    end
    if (!got) chk("gnt_seen", 128'(m0_gnt | m1_gnt), 128'(1));
    else      chk("one_gnt", 128'(m0_gnt & m1_gnt), 128'(0));
  endtask

  task automatic wait_done(input int max, output int cycles);
    bit   got = 1'b0;
    exp_t e;
    cycles = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (m0_done || m1_done) begin
        cycles = i;
        got    = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("done_seen", 128'(m0_done | m1_done), 128'(1));
    end else begin
      chk("one_done", 128'(m0_done & m1_done), 128'(0));
      if (exp_q.size() == 0) begin
        chk("sb_has_entry", 128'(exp_q.size()), 128'(1));
      end else begin
        e = exp_q.pop_front();
        chk("done_who", 128'(m1_done), 128'(e.who));
        chk("done_rdata", 128'(rdata), 128'(e.rdata));
        chk("done_err", 128'(err), 128'(e.err));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int who, cyc;
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
    bus_rdata = '0; bus_ack = 0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", all_out(), 128'(0));

    // m0 read, ack in the first WAIT cycle.
    reset = 1; m0_req = 1; m0_wr = 0; m0_addr = 32'hF000_0014;
    push_exp(1'b0, 32'h2A5, 1'b0);
    wait_gnt(3, who, cyc);
    chk("rd_gnt_who", 128'(who), 128'(0));
    chk("rd_gnt_lat", 128'(cyc), 128'(1));
    chk("rd_addr", 128'(bus_addr), 128'(32'hF000_0014));
    chk("rd_oe", 128'(bus_oe), 128'(0));
    m0_req = 0; m0_addr = 32'hBAD0_BAD0; m0_wr = 1; bus_ack = 1; bus_rdata = 32'h2A5;
    @(negedge clk);
    chk("rd_wait_addr", 128'(bus_addr), 128'(32'hF000_0014));
    chk("rd_wait_wrt", 128'(bus_wrtEn), 128'(0));
    chk("rd_gnt_pulse", 128'(m0_gnt), 128'(0));
    wait_done(3, cyc);
    chk("rd_done_lat", 128'(cyc), 128'(1));
    bus_ack = 0; m0_wr = 0;
    @(negedge clk);
    chk("idle_addr", 128'(bus_addr), 128'(0));
    chk("done_pulse", 128'(m0_done), 128'(0));

    // m1 write: one-cycle strobe, done two cycles after gnt.
    m1_req = 1; m1_wr = 1; m1_addr = 32'hF000_0004; m1_wdata = 32'h0F;
    push_exp(1'b1, 32'h0, 1'b0);
    wait_gnt(3, who, cyc);
    chk("wr_gnt_who", 128'(who), 128'(1));
    chk("wr_strobe", 128'({bus_wrtEn, bus_oe}), 128'(2'b11));
    chk("wr_wdata", 128'(bus_wdata), 128'(32'h0F));
    chk("wr_addr", 128'(bus_addr), 128'(32'hF000_0004));
    m1_req = 0; m1_wdata = 32'h77; bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_strobe_off", 128'({bus_wrtEn, bus_oe}), 128'(2'b00));
    wait_done(3, cyc);
    chk("wr_done_lat", 128'(cyc + 1), 128'(2));
    bus_ack = 0;
    @(negedge clk);

    // Both masters request continuously for four transactions.
    m0_req = 1; m1_req = 1; m0_wr = 0; m1_wr = 0;
    m0_addr = 32'h10; m1_addr = 32'h20; bus_ack = 1; bus_rdata = 32'h1234;
    for (int i = 0; i < 4; i++) push_exp(1'(i % 2), 32'h1234, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_gnt(3, who, cyc);
      chk("rr_order", 128'(who), 128'(i % 2));
      chk("fp_m0_only", 128'({fp_m0_gnt, fp_m1_gnt}), 128'(2'b10));
      if (i == 3) begin
        m0_req = 0; m1_req = 0;
      end
      wait_done(4, cyc);
    end
    bus_ack = 0;
    @(negedge clk);

    // m0 read that never gets an ack.
    m0_req = 1; m0_addr = 32'h100; bus_rdata = 32'h5555;
    push_exp(1'b0, 32'h0, 1'b1);
    wait_gnt(3, who, cyc);
    chk("to_gnt_who", 128'(who), 128'(0));
    m0_req = 0;
    wait_done(12, cyc);
    chk("to_wait_cycles", 128'(cyc - 1), 128'(8));
    @(negedge clk);

    // Reset during WAIT of an m1 read, then a fresh request.
    m1_req = 1; m1_wr = 0; m1_addr = 32'hF000_0008;
    wait_gnt(3, who, cyc);
    chk("rst_gnt_who", 128'(who), 128'(1));
    m1_req = 0;
    @(negedge clk);
    #2 reset = 0;
    #1 chk("rst_async_outputs", all_out(), 128'(0));
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 128'({m0_done, m1_done}), 128'(0));
    end
    m1_req = 1; reset = 1; bus_ack = 1; bus_rdata = 32'hABC;
    push_exp(1'b1, 32'hABC, 1'b0);
    wait_gnt(1, who, cyc);
    chk("post_rst_gnt", 128'(who), 128'(1));
    m1_req = 0;
    wait_done(3, cyc);
    chk("post_rst_done_lat", 128'(cyc), 128'(2));
    bus_ack = 0;
    @(negedge clk);

    chk("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter DBITS, default 32, width of address and data buses.
REQ-002 Parameter TIMEOUT, default 8, maximum WAIT cycles before a transaction is aborted; legal range 1..15.
REQ-003 Parameter FIXED_PRI, default 0; 0 selects round-robin arbitration, 1 makes m0 always win.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 m0_req/m1_req  input  1  bus request from master 0 (CPU pipeline) / master 1 (secondary master).
REQ-007 m0_wr/m1_wr  input  1  1 = write, 0 = read; qualified by req.
REQ-008 m0_addr/m1_addr  input  DBITS  byte address of the access.
REQ-009 m0_wdata/m1_wdata  input  DBITS  write data.
REQ-010 m0_gnt/m1_gnt  output  1  one-cycle pulse: request accepted and operands latched.
REQ-011 m0_done/m1_done  output  1  one-cycle pulse: transaction complete.
REQ-012 err  output  1  valid with a done pulse; 1 = timeout abort.
REQ-013 rdata  output  DBITS  read data; valid with a done pulse.
REQ-014 bus_addr  output  DBITS  address driven to the device bus.
REQ-015 bus_wdata  output  DBITS  data the top level drives onto the tri-state dbus when bus_oe = 1.
REQ-016 bus_oe  output  1  dbus output enable.
REQ-017 bus_wrtEn  output  1  device write strobe.
REQ-018 bus_rdata  input  DBITS  dbus value read back.
REQ-019 bus_ack  input  1  an addressed device responded.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, ADDR, WAIT and RESP.
REQ-021 IDLE, arbitration: with no req asserted, the FSM SHALL stay in IDLE.
REQ-022 IDLE, single request: if only one req is high, that master SHALL win.
REQ-023 IDLE, both requests: the master not granted last SHALL win; with FIXED_PRI = 1, m0 SHALL win.
REQ-024 IDLE, on a win: the FSM SHALL latch the winner's wr, addr and wdata, pulse its gnt, clear the WAIT counter and move to ADDR.
REQ-025 The gnt pulse SHALL be registered and high during the ADDR cycle only.
REQ-026 The last-granted pointer SHALL update on entry to ADDR.
REQ-027 ADDR: bus_addr SHALL equal the latched address.
REQ-028 ADDR: bus_wrtEn and bus_oe SHALL equal the latched wr, so a write strobe lasts exactly one cycle.
REQ-029 ADDR: bus_ack SHALL be ignored, and the next state SHALL be WAIT.
REQ-030 WAIT: bus_addr SHALL be held, and bus_wrtEn and bus_oe SHALL be 0.
REQ-031 WAIT with bus_ack = 1: the FSM SHALL capture bus_rdata into rdata (reads only; rdata = 0 for writes), set err = 0 and go to RESP.
REQ-032 WAIT with bus_ack = 0: the counter SHALL increment; if the counter reaches TIMEOUT, the FSM SHALL set err = 1 and rdata = 0 and go to RESP.
REQ-033 RESP: the FSM SHALL pulse done to the owning master for one cycle, with rdata and err stable, and return to IDLE.
REQ-034 The next arbitration SHALL occur in the IDLE cycle that follows RESP.
REQ-035 Minimum latency SHALL be 3 cycles, from req sampled in IDLE to done: gnt at +1, WAIT at +2, done at +3 when ack arrives in the first WAIT cycle.
REQ-036 A requester SHALL hold req until gnt.
REQ-037 Deasserting req after gnt SHALL NOT abort the transaction.
REQ-038 req, wr, addr and wdata changes after gnt SHALL be ignored.
REQ-039 While busy, a pending request from the other master SHALL wait in IDLE arbitration and SHALL NOT be lost.
REQ-040 Outside ADDR and WAIT, bus_addr SHALL be 0.
REQ-041 At most one gnt and at most one done SHALL be high in any cycle.

Reset
REQ-042 While reset = 0, the FSM SHALL be in IDLE with every output and internal register at 0 and the pointer favouring m0.
REQ-043 Reset asserted mid-transaction SHALL drop the transaction immediately with no done pulse, and bus_wrtEn and bus_oe SHALL fall asynchronously.
REQ-044 After reset deasserts, the first arbitration SHALL occur on the first rising edge.

Verification
REQ-045 m0 read to addr 0xF0000014 with bus_ack in the first WAIT cycle and bus_rdata = 0x2A5 -> m0_gnt at +1, m0_done at +3, rdata = 0x2A5, err = 0.
REQ-046 m1 write of 0x0F to 0xF0000004 -> bus_wrtEn = 1 and bus_oe = 1 for exactly one cycle with bus_wdata = 0x0F; m1_done 2 cycles after m1_gnt.
REQ-047 m0 and m1 request together continuously for 4 transactions, FIXED_PRI = 0 -> grant order m0, m1, m0, m1; with FIXED_PRI = 1 -> m0 on every grant.
REQ-048 m0 read with bus_ack never asserted, TIMEOUT = 8 -> 8 WAIT cycles, then m0_done with err = 1 and rdata = 0.
REQ-049 reset pulled low during a WAIT cycle of an m1 read -> all outputs 0 immediately, no m1_done; after release, a fresh m1_req is granted on the first edge.
